// File: rtl/edge_collision_checker.sv
// edge_collision_checker: walks the Bresenham line between two map cells,
// reads every cell from an external map RAM (one-cycle read latency) and
// reports whether any visited cell is occupied plus how many were evaluated.
// Optional macro EDGE_EARLY_EXIT_EN: the first occupied cell ends the walk.
module edge_collision_checker #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               map_rd_en,
  output logic [COORD_W-1:0] map_x_addr,
  output logic [COORD_W-1:0] map_y_addr,
  input  logic               map_data,
  output logic               done,
  output logic               collision,
  output logic [CNT_W-1:0]   cells_checked
);

  // Error term needs sign plus one guard bit; 2*err needs one more.
  localparam int ERR_W = COORD_W + 2;
  localparam int E2_W  = COORD_W + 3;

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COORD_W-1:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0]      end_x_q, end_x_d, end_y_q, end_y_d;
  logic [COORD_W-1:0]      addr_x_q, addr_x_d, addr_y_q, addr_y_d;
  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                    sx_q, sx_d, sy_q, sy_d;
  logic                    pending_q, pending_d;
  logic                    collision_q, collision_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [COORD_W-1:0]      abs_dx, abs_dy;
  logic signed [E2_W-1:0]  e2, dx_ext, dy_ext;
  logic signed [ERR_W-1:0] err_step;
  logic                    at_end, early_hit, issue;

  // Next-state, Bresenham datapath, read-sample accumulation and outputs.
  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    end_x_d     = end_x_q;
    end_y_d     = end_y_q;
    addr_x_d    = addr_x_q;
    addr_y_d    = addr_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    pending_d   = 1'b0;
    collision_d = collision_q;
    cnt_d       = cnt_q;
    issue       = 1'b0;

    abs_dx = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    abs_dy = (y1 >= y0) ? (y1 - y0) : (y0 - y1);

    e2     = {err_q, 1'b0};
    dx_ext = {dx_q[ERR_W-1], dx_q};
    dy_ext = {dy_q[ERR_W-1], dy_q};
    err_step = err_q;
    if (e2 >= dy_ext) err_step = err_step + dy_q;
    if (e2 <= dx_ext) err_step = err_step + dx_q;

    at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

    // A read issued last cycle returns its data now.
    if (pending_q) begin
      cnt_d       = cnt_q + 1'b1;
      collision_d = collision_q | map_data;
    end

`ifdef EDGE_EARLY_EXIT_EN
    early_hit = pending_q && map_data && (state_q == WALK);
`else
    early_hit = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_x_d     = x0;
          cur_y_d     = y0;
          end_x_d     = x1;
          end_y_d     = y1;
          dx_d        = $signed({2'b00, abs_dx});
          dy_d        = -$signed({2'b00, abs_dy});
          err_d       = $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
          sx_d        = (x1 >= x0);
          sy_d        = (y1 >= y0);
          collision_d = 1'b0;
          cnt_d       = '0;
          state_d     = WALK;
        end
      end
      WALK: begin
        if (early_hit) begin
          // Occupied cell found: drop the point that would issue now.
          state_d = DONE;
        end else begin
          issue     = 1'b1;
          pending_d = 1'b1;
          addr_x_d  = cur_x_q;
          addr_y_d  = cur_y_q;
          if (at_end) begin
            state_d = DRAIN;
          end else begin
            err_d = err_step;
            if (e2 >= dy_ext) cur_x_d = sx_q ? (cur_x_q + 1'b1) : (cur_x_q - 1'b1);
            if (e2 <= dx_ext) cur_y_d = sy_q ? (cur_y_q + 1'b1) : (cur_y_q - 1'b1);
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready     = (state_q == IDLE);
    done          = (state_q == DONE);
    map_rd_en     = issue;
    map_x_addr    = issue ? cur_x_q : addr_x_q;
    map_y_addr    = issue ? cur_y_q : addr_y_q;
    collision     = collision_q;
    cells_checked = cnt_q;
  end

  // State register with synchronous reset that aborts any walk in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      addr_x_q    <= '0;
      addr_y_q    <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      pending_q   <= 1'b0;
      collision_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      end_x_q     <= end_x_d;
      end_y_q     <= end_y_d;
      addr_x_q    <= addr_x_d;
      addr_y_q    <= addr_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pending_q   <= pending_d;
      collision_q <= collision_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_edge_collision_checker.sv
// Testbench for edge_collision_checker: directed edges plus randomized edges
// and maps, checked against a point-list reference model of the line walk.
module tb_edge_collision_checker;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 11;
  localparam int MAXC    = (1 << COORD_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [COORD_W-1:0] x0_i = '0, y0_i = '0, x1_i = '0, y1_i = '0;
  logic               map_rd_en;
  logic [COORD_W-1:0] map_x_addr, map_y_addr;
  logic               map_data;
  logic               done;
  logic               collision;
  logic [CNT_W-1:0]   cells_checked;

  int n_vec  = 0;
  int n_miss = 0;
  bit preload = 1'b0;
  int nxt_x0, nxt_y0, nxt_x1, nxt_y1;

  bit occ_map[int];

  always #5 clk = ~clk;

  edge_collision_checker #(.COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .x0(x0_i), .y0(y0_i), .x1(x1_i), .y1(y1_i),
    .map_rd_en(map_rd_en), .map_x_addr(map_x_addr), .map_y_addr(map_y_addr),
    .map_data(map_data), .done(done), .collision(collision),
    .cells_checked(cells_checked)
  );

  function automatic int key(input int x, input int y);
    return x * 4096 + y;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Map RAM model: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (map_rd_en) map_data <= occ_map.exists(key(int'(map_x_addr), int'(map_y_addr))) != 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one edge: drives the request (unless already pending), watches the
  // walk cycle by cycle and compares against the reference point list.
  task automatic run_edge(input int ax0, input int ay0, input int ax1, input int ay1, input bit hold);
    int px[$], py[$], gx[$], gy[$];
    int dx, dy, sx, sy, err, e2, x, y;
    int n, hit, exp_cells, exp_done, exp_issue, done_cyc, ready_bad;
    bit exp_coll;
    logic got_coll;
    logic [CNT_W-1:0] got_cells;

    // Reference: Bresenham point list from start to end.
    dx = iabs(ax1 - ax0);
    dy = -iabs(ay1 - ay0);
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    forever begin
      px.push_back(x);
      py.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    n = ((dx > -dy) ? dx : -dy) + 1;
    hit = -1;
    foreach (px[i]) if (hit < 0 && occ_map.exists(key(px[i], py[i]))) hit = i;
    exp_coll  = (hit >= 0);
    exp_cells = n;
    exp_done  = n + 2;
    exp_issue = n;
`ifdef EDGE_EARLY_EXIT_EN
    if (hit >= 0) begin
      exp_cells = hit + 1;
      exp_done  = hit + 3;
      exp_issue = hit + 1;
    end
`endif

    if (!preload) begin
      @(negedge clk);
      x0_i = COORD_W'(ax0); y0_i = COORD_W'(ay0);
      x1_i = COORD_W'(ax1); y1_i = COORD_W'(ay1);
      req_valid = 1'b1;
    end
    preload = 1'b0;
    chk("ready_before", req_ready, 1);
    @(posedge clk);

    done_cyc  = -1;
    ready_bad = 0;
    got_coll  = 1'b0;
    got_cells = '0;
    for (int c = 1; c <= 2100; c++) begin
      @(negedge clk);
      if (map_rd_en) begin
        gx.push_back(int'(map_x_addr));
        gy.push_back(int'(map_y_addr));
      end
      if (done) begin
        done_cyc  = c;
        got_coll  = collision;
        got_cells = cells_checked;
        chk("addr_hold", key(int'(map_x_addr), int'(map_y_addr)),
            key(px[exp_issue-1], py[exp_issue-1]));
        break;
      end
      if (req_ready) ready_bad++;
      if (c == 1) begin
        if (hold) begin
          x0_i = COORD_W'(nxt_x0); y0_i = COORD_W'(nxt_y0);
          x1_i = COORD_W'(nxt_x1); y1_i = COORD_W'(nxt_y1);
        end else begin
          req_valid = 1'b0;
        end
      end
    end

    chk("done_cycle", done_cyc, exp_done);
    chk("collision", got_coll, exp_coll);
    chk("cells_checked", got_cells, exp_cells);
    chk("busy_ready", ready_bad, 0);
    chk("issue_count", gx.size(), exp_issue);
    for (int i = 0; i < exp_issue && i < gx.size(); i++)
      chk("addr", key(gx[i], gy[i]), key(px[i], py[i]));

    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_ready", req_ready, 1);
    if (hold) preload = 1'b1;

    $display("edge (%0d,%0d)->(%0d,%0d): done@%0d (exp %0d) coll=%0d cells=%0d reads=%0d",
             ax0, ay0, ax1, ay1, done_cyc, exp_done, got_coll, got_cells, gx.size());
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_coll", collision, 0);
    chk("rst_cells", cells_checked, 0);
    chk("rst_rd_en", map_rd_en, 0);
    chk("rst_addr", key(int'(map_x_addr), int'(map_y_addr)), 0);
    reset = 1'b0;

    // Free map and occupied-cell variants of the reference edge.
    occ_map.delete();
    run_edge(0, 0, 5, 3, 0);
    occ_map[key(3, 2)] = 1;
    run_edge(0, 0, 5, 3, 0);
    occ_map.delete();
    occ_map[key(7, 7)] = 1;
    run_edge(7, 7, 7, 7, 0);
    occ_map.delete();
    run_edge(5, 3, 0, 0, 0);

    // Request held through a walk is taken only once the block is idle.
    nxt_x0 = 2; nxt_y0 = 9; nxt_x1 = 6; nxt_y1 = 1;
    run_edge(0, 0, 5, 3, 1);
    run_edge(2, 9, 6, 1, 0);

    // Reset wins over a simultaneous acceptance.
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b1;
    x0_i = 1; y0_i = 1; x1_i = 4; y1_i = 4;
    @(negedge clk);
    chk("rstprio_rd_en", map_rd_en, 0);
    chk("rstprio_ready", req_ready, 1);
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstprio_idle", map_rd_en, 0);

    // Reset in cycle 3 of a walk aborts it; a fresh request follows at once.
    occ_map.delete();
    occ_map[key(0, 0)] = 1;
    @(negedge clk);
    x0_i = 0; y0_i = 0; x1_i = 20; y1_i = 10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rd_en", map_rd_en, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_coll", collision, 0);
    chk("abort_cells", cells_checked, 0);
    reset = 1'b0;
    x0_i = 2; y0_i = 3; x1_i = 8; y1_i = 5;
    req_valid = 1'b1;
    preload = 1'b1;
    run_edge(2, 3, 8, 5, 0);

    // Full-range diagonal with the final cell occupied.
    occ_map.delete();
    occ_map[key(MAXC, 0)] = 1;
    run_edge(0, MAXC, MAXC, 0, 0);

    // Randomized edges inside small boxes with sparse random obstacles.
    for (int t = 0; t < 30; t++) begin
      int bx, by, wx, wy, ax0, ay0, ax1, ay1, k;
      bx = $urandom_range(0, MAXC - 40);
      by = $urandom_range(0, MAXC - 40);
      wx = $urandom_range(0, 40);
      wy = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin ax0 = bx; ax1 = bx + wx; end
      else begin ax0 = bx + wx; ax1 = bx; end
      if ($urandom_range(0, 1) == 1) begin ay0 = by; ay1 = by + wy; end
      else begin ay0 = by + wy; ay1 = by; end
      occ_map.delete();
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++)
        occ_map[key(bx + $urandom_range(0, wx), by + $urandom_range(0, wy))] = 1;
      run_edge(ax0, ay0, ax1, ay1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
